fir_coeff_load_ctrl: RTL and testbench

Sequencer that owns the coefficient SRAM port of the reconfigurable FIR filter and controls filter enable during reconfiguration. While the host holds the update flag, host SRAM writes are passed through with one register stage and the filter accumulator is frozen. When the flag drops, the block reads all taps back from SRAM in order and drives a coefficient-bank write strobe for each. It then re-enables the filter. It sits between the host/test port, the single-port SRAM and the tap-coefficient register bank.

---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_tap_counter.sv | 40 ++++
 rtl/fir_coeff_load_ctrl.sv | 161 ++++++++++++++++
 tb/tb_fir_coeff_load_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the reconfigurable FIR filter coefficient path.
// Holds the coefficient-load sequencer state encoding, the default filter
// geometry and a small state-decode helper used by the sequencer.
package fir_pkg;

  localparam int FIR_NUM_TAPS = 33;
  localparam int FIR_COEFF_W  = 16;
  localparam int FIR_ADDR_W   = 6;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    HOST_WR  = 3'd2,
    READBACK = 3'd3,
    DRAIN    = 3'd4
  } ctrlState_e;

  // The filter is considered busy whenever the coefficient bank is being
  // rewritten or may be inconsistent with SRAM.
  function automatic logic isBusy(input ctrlState_e s);
    return s inside {HOST_WR, READBACK, DRAIN};
  endfunction

endpackage

// File: rtl/fir_tap_counter.sv
// Loadable up-counter used as the coefficient readback index.
// Ports:
//   clk, rstN  - clock and asynchronous active-low reset
//   load       - load loadVal (takes priority over inc)
//   loadVal    - value loaded on load
//   inc        - advance count by one
//   count      - current tap index
//   termCnt    - high while count == NUM_TAPS-1 (last tap)
module fir_tap_counter
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = FIR_NUM_TAPS,
  parameter int ADDR_W   = FIR_ADDR_W
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              load,
  input  logic [ADDR_W-1:0] loadVal,
  input  logic              inc,
  output logic [ADDR_W-1:0] count,
  output logic              termCnt
);

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // The sequencer stops incrementing at the terminal count, so the counter
  // never needs to wrap.
  assign termCnt = (count == ADDR_W'(NUM_TAPS - 1));

endmodule

// File: rtl/fir_coeff_load_ctrl.sv
// Coefficient load sequencer for the reconfigurable FIR filter.
// Owns the single-port coefficient SRAM. While iCoeffiUpdateFlag is high the
// host port is registered straight onto the SRAM port and the filter is
// frozen; when the flag drops, every tap is read back in order and written
// into the tap-coefficient register bank, then the filter is re-enabled.
// Ports:
//   iClk_12M, iRsn      - clock, asynchronous active-low reset
//   iCoeffiUpdateFlag   - host update window request (level)
//   iCsnRam/iWrnRam/iAddrRam/iWrDtRam - host SRAM access (active-low strobes)
//   iRdDtRam            - SRAM read data, one cycle after the read request
//   oCsnRam/oWrnRam/oAddrRam/oWrDtRam - SRAM port (registered)
//   oCoeffWe/oCoeffIdx/oCoeffDt       - coefficient bank write (registered)
//   oEnAcc              - filter accumulate/shift enable
//   oBusy               - update or readback in progress
//   oDone               - one-cycle pulse on readback completion
module fir_coeff_load_ctrl
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = FIR_NUM_TAPS,
  parameter int DATA_W   = FIR_COEFF_W,
  parameter int ADDR_W   = FIR_ADDR_W
) (
  input  logic              iClk_12M,
  input  logic              iRsn,
  input  logic              iCoeffiUpdateFlag,
  input  logic              iCsnRam,
  input  logic              iWrnRam,
  input  logic [ADDR_W-1:0] iAddrRam,
  input  logic [DATA_W-1:0] iWrDtRam,
  input  logic [DATA_W-1:0] iRdDtRam,
  output logic              oCsnRam,
  output logic              oWrnRam,
  output logic [ADDR_W-1:0] oAddrRam,
  output logic [DATA_W-1:0] oWrDtRam,
  output logic              oCoeffWe,
  output logic [ADDR_W-1:0] oCoeffIdx,
  output logic [DATA_W-1:0] oCoeffDt,
  output logic              oEnAcc,
  output logic              oBusy,
  output logic              oDone
);

  ctrlState_e        state, nextState;
  logic [ADDR_W-1:0] tapIdx;
  logic              tapLast;
  logic              cntLoad, cntInc;
  logic              hostLegal;

  logic              csnNxt, wrnNxt, doneNxt;
  logic [ADDR_W-1:0] addrNxt;
  logic [DATA_W-1:0] wrDtNxt;
  // High in the cycle after a readback read was issued: iRdDtRam then holds
  // the word addressed by oAddrRam.
  logic              rdPend, rdPendNxt;

  fir_tap_counter #(
    .NUM_TAPS(NUM_TAPS),
    .ADDR_W  (ADDR_W)
  ) uTapCounter (
    .clk    (iClk_12M),
    .rstN   (iRsn),
    .load   (cntLoad),
    .loadVal('0),
    .inc    (cntInc),
    .count  (tapIdx),
    .termCnt(tapLast)
  );

  // Host accesses beyond the last tap never reach the SRAM.
  assign hostLegal = ({1'b0, iAddrRam} < (ADDR_W + 1)'(NUM_TAPS));

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // NOTE: every signal driven here gets a default before the case so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    nextState = state;
    csnNxt    = 1'b1;
    wrnNxt    = 1'b1;
    addrNxt   = oAddrRam;
    wrDtNxt   = oWrDtRam;
    rdPendNxt = 1'b0;
    doneNxt   = 1'b0;
    cntLoad   = 1'b0;
    cntInc    = 1'b0;

    unique case (state)
      IDLE, RUN: begin
        if (iCoeffiUpdateFlag) nextState = HOST_WR;
      end
      HOST_WR: begin
        // Port stays idle in the hand-over cycle; the counter restarts at 0.
        if (!iCoeffiUpdateFlag) begin
          nextState = READBACK;
          cntLoad   = 1'b1;
        end
      end
      READBACK: begin
        csnNxt    = 1'b0;
        addrNxt   = tapIdx;
        rdPendNxt = 1'b1;
        cntInc    = 1'b1;
        if (tapLast) nextState = DRAIN;
      end
      DRAIN: begin
        nextState = RUN;
        doneNxt   = 1'b1;
      end
      default: nextState = IDLE;
    endcase

    // Host passthrough for every cycle that ends up in HOST_WR.
    if (nextState == HOST_WR) begin
      addrNxt = iAddrRam;
      wrDtNxt = iWrDtRam;
      if (hostLegal) begin
        csnNxt = iCsnRam;
        wrnNxt = iWrnRam;
      end
    end
  end

  // Outputs are registered alongside the state, so they describe the state
  // being entered at each edge.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      oCsnRam   <= 1'b1;
      oWrnRam   <= 1'b1;
      oAddrRam  <= '0;
      oWrDtRam  <= '0;
      oCoeffWe  <= 1'b0;
      oCoeffIdx <= '0;
      oCoeffDt  <= '0;
      oEnAcc    <= 1'b0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      rdPend    <= 1'b0;
    end else begin
      oCsnRam  <= csnNxt;
      oWrnRam  <= wrnNxt;
      oAddrRam <= addrNxt;
      oWrDtRam <= wrDtNxt;
      oEnAcc   <= (nextState == RUN);
      oBusy    <= isBusy(nextState);
      oDone    <= doneNxt;
      rdPend   <= rdPendNxt;
      oCoeffWe <= rdPend;
      if (rdPend) begin
        oCoeffIdx <= oAddrRam;
        oCoeffDt  <= iRdDtRam;
      end
    end
  end

endmodule

// File: tb/tb_fir_coeff_load_ctrl.sv
// Self-checking bench for fir_coeff_load_ctrl. Provides a behavioural SRAM,
// a reference coefficient image built from host writes, and one task per
// scenario. Timing expectations are derived from the cycle offsets of the
// readback sequence counted from the clock edge after the flag is dropped.
module tb_fir_coeff_load_ctrl;
  import fir_pkg::*;

  localparam int NT = FIR_NUM_TAPS;
  localparam int DW = FIR_COEFF_W;
  localparam int AW = FIR_ADDR_W;
  localparam logic [49:0] RST_VEC = {2'b11, 48'd0};

  logic          clk = 1'b0;
  logic          rsn;
  logic          iCoeffiUpdateFlag;
  logic          iCsnRam, iWrnRam;
  logic [AW-1:0] iAddrRam;
  logic [DW-1:0] iWrDtRam, iRdDtRam;
  logic          oCsnRam, oWrnRam;
  logic [AW-1:0] oAddrRam;
  logic [DW-1:0] oWrDtRam;
  logic          oCoeffWe;
  logic [AW-1:0] oCoeffIdx;
  logic [DW-1:0] oCoeffDt;
  logic          oEnAcc, oBusy, oDone;

  int nChecks = 0;
  int nFails  = 0;

  logic [DW-1:0] sram [2**AW];
  logic          sramClear;
  logic [DW-1:0] expCoeff [NT];

  always #5 clk = ~clk;

  fir_coeff_load_ctrl dut (
    .iClk_12M         (clk),
    .iRsn             (rsn),
    .iCoeffiUpdateFlag(iCoeffiUpdateFlag),
    .iCsnRam          (iCsnRam),
    .iWrnRam          (iWrnRam),
    .iAddrRam         (iAddrRam),
    .iWrDtRam         (iWrDtRam),
    .iRdDtRam         (iRdDtRam),
    .oCsnRam          (oCsnRam),
    .oWrnRam          (oWrnRam),
    .oAddrRam         (oAddrRam),
    .oWrDtRam         (oWrDtRam),
    .oCoeffWe         (oCoeffWe),
    .oCoeffIdx        (oCoeffIdx),
    .oCoeffDt         (oCoeffDt),
    .oEnAcc           (oEnAcc),
    .oBusy            (oBusy),
    .oDone            (oDone)
  );

  // SRAM: writes on the clock edge; read data follows the registered address,
  // so it is valid in the cycle after the controller issues the request.
  always @(posedge clk) begin
    if (sramClear) begin
      for (int i = 0; i < 2**AW; i++) sram[i] <= 16'hDEAD;
    end else if (!oCsnRam && !oWrnRam) begin
      sram[oAddrRam] <= oWrDtRam;
    end
  end
  assign iRdDtRam = sram[oAddrRam];

  function automatic logic [49:0] outVec();
    return {oCsnRam, oWrnRam, oAddrRam, oWrDtRam, oCoeffWe, oCoeffIdx,
            oCoeffDt, oEnAcc, oBusy, oDone};
  endfunction

  task automatic test_reset();
    rsn = 1'b0; iCoeffiUpdateFlag = 1'b0; iCsnRam = 1'b1; iWrnRam = 1'b1;
    iAddrRam = '0; iWrDtRam = '0; sramClear = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nChecks++;
    if (outVec() !== RST_VEC) begin
      nFails++;
      $display("FAIL reset_values: got %h expected %h", outVec(), RST_VEC);
    end
    @(negedge clk);
    sramClear = 1'b0;
    rsn = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      nChecks++;
      if ({oEnAcc, oCsnRam, oCoeffWe, oBusy, oDone} !== 5'b01000) begin
        nFails++;
        $display("FAIL idle_cycle %0d: got en/csn/we/busy/done=%b expected 01000",
                 n, {oEnAcc, oCsnRam, oCoeffWe, oBusy, oDone});
      end
    end
  endtask

  task automatic enterHostWr(input logic prevEn);
    @(negedge clk);
    nChecks++;
    if (oEnAcc !== prevEn) begin
      nFails++;
      $display("FAIL en_before_update: got %b expected %b", oEnAcc, prevEn);
    end
    iCoeffiUpdateFlag = 1'b1;
    @(posedge clk); #1;
    nChecks++;
    if ({oEnAcc, oBusy, oCsnRam} !== 3'b011) begin
      nFails++;
      $display("FAIL enter_host_wr: got en/busy/csn=%b expected 011",
               {oEnAcc, oBusy, oCsnRam});
    end
  endtask

  task automatic hostAccess(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic isWrite);
    logic          legal;
    logic [24:0]   got, exp;
    legal = (int'(a) < NT);
    @(negedge clk);
    iCsnRam = 1'b0; iWrnRam = ~isWrite; iAddrRam = a; iWrDtRam = d;
    @(posedge clk); #1;
    exp = {~legal, legal ? ~isWrite : 1'b1, 1'b1,
           legal ? a : AW'(0), (legal && isWrite) ? d : DW'(0)};
    got = {oCsnRam, oWrnRam, oBusy,
           legal ? oAddrRam : AW'(0), (legal && isWrite) ? oWrDtRam : DW'(0)};
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL host_access addr=%0d wr=%b: got csn/wrn/busy/addr/dt=%h expected %h",
               a, isWrite, got, exp);
    end
    if (legal && isWrite) expCoeff[a] = d;
  endtask

  // Edge 1 is the first rising edge with the flag low. Reads appear on edges
  // 2..NT+1, bank writes on edges 3..NT+2, oDone and the first RUN cycle on
  // edge NT+2.
  task automatic runReadback(input int glitchAt, input int holdAt, input string tag);
    int          lastEdge;
    logic        expWe, expRd, expEn, expBusy;
    logic [33:0] got, exp;
    logic [AW-1:0] eIdx, eAddr;
    logic [DW-1:0] eDt;
    lastEdge = (holdAt > 0) ? NT + 3 : NT + 4;
    for (int n = 1; n <= lastEdge; n++) begin
      @(negedge clk);
      if (n == 1) begin
        iCsnRam = 1'b1; iWrnRam = 1'b1;
      end
      iCoeffiUpdateFlag = (glitchAt > 0 && n >= glitchAt && n < glitchAt + 3) ||
                          (holdAt > 0 && n >= holdAt);
      @(posedge clk); #1;
      expWe = (n >= 3) && (n <= NT + 2);
      expRd = (n >= 2) && (n <= NT + 1);
      eIdx = '0; eDt = '0; eAddr = '0;
      if (expWe) begin
        eIdx = AW'(n - 3);
        eDt  = expCoeff[n - 3];
      end
      if (expRd) eAddr = AW'(n - 2);
      expEn   = (n == NT + 2) || (n > NT + 2 && holdAt == 0);
      expBusy = (n <= NT + 1) || (holdAt > 0 && n == NT + 3);
      exp = {expWe, eIdx, eDt, ~expRd, 1'b1, eAddr, n == NT + 2, expEn, expBusy};
      got = {oCoeffWe, oCoeffWe ? oCoeffIdx : AW'(0), oCoeffWe ? oCoeffDt : DW'(0),
             oCsnRam, oWrnRam, !oCsnRam ? oAddrRam : AW'(0), oDone, oEnAcc, oBusy};
      nChecks++;
      if (got !== exp) begin
        nFails++;
        $display("FAIL readback_%s edge %0d: got we/idx/dt/csn/wrn/addr/done/en/busy=%h expected %h",
                 tag, n, got, exp);
      end
    end
  endtask

  task automatic test_load_ramp();
    enterHostWr(1'b0);
    for (int k = 0; k < NT; k++) hostAccess(AW'(k), DW'(16'h0100 + k), 1'b1);
    runReadback(0, 0, "ramp");
  endtask

  task automatic test_blocked();
    enterHostWr(1'b1);
    hostAccess(AW'(40), DW'($urandom), 1'b1);
    hostAccess(AW'(63), DW'($urandom), 1'b1);
    hostAccess(AW'(5), DW'($urandom), 1'b0);
    hostAccess(AW'($urandom_range(0, NT - 1)), DW'($urandom), 1'b1);
    hostAccess(AW'(NT), DW'($urandom), 1'b1);
    runReadback(0, 0, "blocked");
    nChecks++;
    if ({sram[40], sram[63], sram[NT]} !== {3{16'hDEAD}}) begin
      nFails++;
      $display("FAIL blocked_sram: got %h %h %h expected dead dead dead",
               sram[40], sram[63], sram[NT]);
    end
  endtask

  task automatic test_flag_glitch();
    enterHostWr(1'b1);
    for (int k = 0; k < 8; k++)
      hostAccess(AW'($urandom_range(0, NT - 1)), DW'($urandom), 1'b1);
    runReadback(15, 0, "glitch");
  endtask

  task automatic test_reset_mid();
    logic found;
    enterHostWr(1'b1);
    for (int k = 0; k < NT; k++) hostAccess(AW'(k), DW'($urandom), 1'b1);
    @(negedge clk);
    iCoeffiUpdateFlag = 1'b0; iCsnRam = 1'b1; iWrnRam = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 2 * NT && !found; n++) begin
      @(posedge clk); #1;
      if (oCoeffWe && oCoeffIdx == AW'(17)) found = 1'b1;
    end
    nChecks++;
    if (!found) begin
      nFails++;
      $display("FAIL wait_idx17: got no write of tap 17 expected one within %0d cycles", 2 * NT);
    end
    #2 rsn = 1'b0;
    #1;
    nChecks++;
    if (outVec() !== RST_VEC) begin
      nFails++;
      $display("FAIL mid_reset_values: got %h expected %h", outVec(), RST_VEC);
    end
    @(negedge clk);
    @(negedge clk);
    rsn = 1'b1;
    @(posedge clk); #1;
    nChecks++;
    if ({oEnAcc, oBusy, oCsnRam, oCoeffWe} !== 4'b0010) begin
      nFails++;
      $display("FAIL post_reset_idle: got en/busy/csn/we=%b expected 0010",
               {oEnAcc, oBusy, oCsnRam, oCoeffWe});
    end
    enterHostWr(1'b0);
    runReadback(0, 0, "after_reset");
  endtask

  task automatic test_hold_high();
    enterHostWr(1'b1);
    for (int k = 0; k < 4; k++)
      hostAccess(AW'($urandom_range(0, NT - 1)), DW'($urandom), 1'b1);
    runReadback(0, 30, "hold");
  endtask

  initial begin
    for (int i = 0; i < NT; i++) expCoeff[i] = 16'hDEAD;
    test_reset();
    test_load_ramp();
    test_blocked();
    test_flag_glitch();
    test_reset_mid();
    test_hold_high();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
